// File: rtl/cntr_cmd_seq.sv
// Command sequencer: queues LOAD/INC/DEC commands in a 4-deep FIFO and
// drives load/inc/d_in to a downstream 8-bit counter.
//
// state | meaning
// IDLE  | pop next command when the FIFO is non-empty
// LOAD  | one-cycle load strobe to the counter
// RUN   | hold inc direction for n cycles
module cntr_cmd_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       abort,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       load,
  output logic       inc,
  output logic [7:0] d_in,
  output logic [1:0] o_state,
  output logic [2:0] fifo_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count_q;
  logic [7:0]  rem_q, rem_d;
  logic        load_d, inc_d;
  logic [7:0]  d_in_d;
  logic        push, pop;
  logic [1:0]  head_op;
  logic [7:0]  head_data;

  // Ready comes from the registered count only, so a full FIFO never
  // accepts a push even when the FSM pops on the same edge.
  assign cmd_ready  = (count_q != 3'd4);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != 3'd0);
  assign head_op    = fifo_mem[rd_ptr][9:8];
  assign head_data  = fifo_mem[rd_ptr][7:0];
  assign o_state    = state_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != 3'd0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    load_d  = 1'b0;
    inc_d   = inc;
    d_in_d  = d_in;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          case (head_op)
            2'b01: begin
              load_d  = 1'b1;
              d_in_d  = head_data;
              state_d = ST_LOAD;
            end
            2'b10, 2'b11: begin
              if (head_data != 8'd0) begin
                inc_d   = ~head_op[0];
                rem_d   = head_data - 8'd1;
                state_d = ST_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN: begin
        if (rem_q == 8'd0) state_d = ST_IDLE;
        else               rem_d   = rem_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      load    <= 1'b0;
      inc     <= 1'b0;
      d_in    <= 8'h00;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count_q <= 3'd0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      load    <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      load    <= load_d;
      inc     <= inc_d;
      d_in    <= d_in_d;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !abort && push) fifo_mem[wr_ptr] <= {cmd_op, cmd_data};
  end

endmodule

// File: tb/tb_cntr_cmd_seq.sv
// Bench for cntr_cmd_seq: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked against a queue-based command model.
module tb_cntr_cmd_seq;

  logic       clk = 1'b0;
  logic       reset_n, abort, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       load, inc;
  logic [7:0] d_in;
  logic [1:0] o_state;
  logic [2:0] fifo_count;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Model: pending commands, and what the counter is currently being told.
  logic [9:0] mq [$];
  bit         m_in_load;
  int         m_run_left;
  bit         m_load, m_inc;
  logic [7:0] m_din;

  cntr_cmd_seq dut (
    .clk(clk), .reset_n(reset_n), .abort(abort), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .load(load), .inc(inc), .d_in(d_in), .o_state(o_state),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit acc;
    logic [9:0] h;
    if (!reset_n) begin
      mq.delete();
      m_in_load = 0; m_run_left = 0; m_load = 0; m_inc = 0; m_din = 8'h00;
    end else if (abort) begin
      mq.delete();
      m_in_load = 0; m_run_left = 0; m_load = 0;
    end else begin
      acc = cmd_valid && (mq.size() < 4);
      if (m_in_load) begin
        m_in_load = 0;
        m_load = 0;
      end else if (m_run_left > 0) begin
        m_run_left--;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        case (h[9:8])
          2'b01: begin m_in_load = 1; m_load = 1; m_din = h[7:0]; end
          2'b10, 2'b11: if (h[7:0] != 8'd0) begin
            m_inc = (h[9:8] == 2'b10);
            m_run_left = int'(h[7:0]);
          end
          default: ;
        endcase
      end
      if (acc) mq.push_back({cmd_op, cmd_data});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // One compare process: every falling edge, DUT vs model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      automatic int exp_state = m_in_load ? 1 : (m_run_left > 0 ? 2 : 0);
      chk("m_o_state", int'(o_state), exp_state);
      chk("m_load", int'(load), int'(m_load));
      chk("m_inc", int'(inc), int'(m_inc));
      chk("m_d_in", int'(d_in), int'(m_din));
      chk("m_fifo_count", int'(fifo_count), mq.size());
      chk("m_cmd_ready", int'(cmd_ready), int'(mq.size() != 4));
      chk("m_busy", int'(busy), int'(exp_state != 0 || mq.size() != 0));
    end
  end

  // Present a command for one edge; returns at the following falling edge.
  task automatic push(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    @(posedge clk);
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_load", int'(load), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_d_in", int'(d_in), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // LOAD 0x10: one-cycle strobe one edge after the push
    push(2'b01, 8'h10);
    chk("ld_count", int'(fifo_count), 1);
    @(negedge clk);
    chk("ld_load", int'(load), 1);
    chk("ld_d_in", int'(d_in), 8'h10);
    chk("ld_state", int'(o_state), 1);
    @(negedge clk);
    chk("ld_load_clr", int'(load), 0);
    chk("ld_state_idle", int'(o_state), 0);

    // INC n=3 then DEC n=2
    push(2'b10, 8'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("inc3_state", int'(o_state), 2);
      chk("inc3_inc", int'(inc), 1);
    end
    @(negedge clk);
    chk("inc3_done", int'(o_state), 0);
    chk("inc3_held", int'(inc), 1);
    push(2'b11, 8'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("dec2_state", int'(o_state), 2);
      chk("dec2_inc", int'(inc), 0);
    end
    @(negedge clk);
    chk("dec2_done", int'(o_state), 0);

    // NOP and INC n=0 are consumed without leaving IDLE
    push(2'b00, 8'h55);
    push(2'b10, 8'd0);
    chk("nop_state", int'(o_state), 0);
    push(2'b01, 8'hAA);
    chk("inc0_state", int'(o_state), 0);
    @(negedge clk);
    chk("aa_load", int'(load), 1);
    chk("aa_d_in", int'(d_in), 8'hAA);
    repeat (2) @(negedge clk);

    // INC n=200 running, fill the FIFO, 5th push rejected
    push(2'b10, 8'd200);
    push(2'b01, 8'h01);
    push(2'b10, 8'd1);
    push(2'b11, 8'd1);
    push(2'b00, 8'h00);
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(cmd_ready), 0);
    push(2'b01, 8'h77);
    chk("full_5th", int'(fifo_count), 4);
    chk("full_state", int'(o_state), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab1_count", int'(fifo_count), 0);
    chk("ab1_state", int'(o_state), 0);

    // Abort mid-RUN with 3 queued and a same-edge push
    push(2'b11, 8'd50);
    push(2'b01, 8'h33);
    push(2'b10, 8'd4);
    push(2'b00, 8'h00);
    chk("ab2_count_pre", int'(fifo_count), 3);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h99;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    chk("ab2_state", int'(o_state), 0);
    chk("ab2_count", int'(fifo_count), 0);
    chk("ab2_busy", int'(busy), 0);
    chk("ab2_load", int'(load), 0);
    chk("ab2_inc", int'(inc), 0);
    chk("ab2_d_in", int'(d_in), 8'hAA);

    // Randomized phase
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cmd_valid = ($urandom_range(0, 99) < 45);
      cmd_op    = 2'($urandom_range(0, 3));
      if (cmd_op[1] && $urandom_range(0, 9) != 0) cmd_data = 8'($urandom_range(0, 5));
      else                                        cmd_data = 8'($urandom_range(0, 255));
      abort   = ($urandom_range(0, 99) < 2);
      reset_n = !($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset_n = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
